mul_add: RTL and testbench



---
 rtl/mul_add_pkg.sv | 16 +
 rtl/mul_add_sat.sv | 23 ++
 rtl/mul_add.sv | 75 +++++++
 tb/tb_mul_add.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/mul_add_pkg.sv
// mul_add_pkg: shared widths, fixed-point format, types and saturation limits for mul_add
package mul_add_pkg;

    localparam int DATA_W = 17;
    localparam int FRAC_W = 8;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 2 * DATA_W + 4;

    typedef logic signed [DATA_W-1:0] pix_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    localparam pix_t SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam pix_t SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

endpackage

// File: rtl/mul_add_sat.sv
// mul_add_sat: rescale accumulator to pixel format, saturate, optional ReLU (MUL_ADD_RELU_EN)
module mul_add_sat
    import mul_add_pkg::*;
(
    input  logic signed [ACC_W-1:0]  sum,
    output logic signed [DATA_W-1:0] pix
);

    // Arithmetic shift floors toward negative infinity; no rounding term is added.
    acc_t shifted;
    pix_t sat;

    assign shifted = sum >>> FRAC_W;
    assign sat = (shifted > acc_t'(SAT_MAX)) ? SAT_MAX :
                 (shifted < acc_t'(SAT_MIN)) ? SAT_MIN : shifted[DATA_W-1:0];

`ifdef MUL_ADD_RELU_EN
    assign pix = sat[DATA_W-1] ? '0 : sat;
`else
    assign pix = sat;
`endif

endmodule

// File: rtl/mul_add.sv
// mul_add: 3-stage 3x3 convolution MAC (multiply, sum, shift/saturate); ReLU via MUL_ADD_RELU_EN
module mul_add
    import mul_add_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] kernel_weights0,
    input  logic signed [DATA_W-1:0] kernel_weights1,
    input  logic signed [DATA_W-1:0] kernel_weights2,
    input  logic signed [DATA_W-1:0] kernel_weights3,
    input  logic signed [DATA_W-1:0] kernel_weights4,
    input  logic signed [DATA_W-1:0] kernel_weights5,
    input  logic signed [DATA_W-1:0] kernel_weights6,
    input  logic signed [DATA_W-1:0] kernel_weights7,
    input  logic signed [DATA_W-1:0] kernel_weights8,
    input  logic signed [DATA_W-1:0] subimage0,
    input  logic signed [DATA_W-1:0] subimage1,
    input  logic signed [DATA_W-1:0] subimage2,
    input  logic signed [DATA_W-1:0] subimage3,
    input  logic signed [DATA_W-1:0] subimage4,
    input  logic signed [DATA_W-1:0] subimage5,
    input  logic signed [DATA_W-1:0] subimage6,
    input  logic signed [DATA_W-1:0] subimage7,
    input  logic signed [DATA_W-1:0] subimage8,
    output logic signed [DATA_W-1:0] out_pix
);

    pix_t  w [9];
    pix_t  s [9];
    prod_t p [9];
    acc_t  tree;
    acc_t  sum;
    pix_t  sat_pix;

    assign w = '{kernel_weights0, kernel_weights1, kernel_weights2,
                 kernel_weights3, kernel_weights4, kernel_weights5,
                 kernel_weights6, kernel_weights7, kernel_weights8};
    assign s = '{subimage0, subimage1, subimage2,
                 subimage3, subimage4, subimage5,
                 subimage6, subimage7, subimage8};

    // Stage 1: register the nine signed weight*pixel products.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 9; i++) p[i] <= '0;
        end else if (en) begin
            for (int i = 0; i < 9; i++) p[i] <= prod_t'(w[i]) * prod_t'(s[i]);
        end
    end

    // Stage 2 adder tree: sign-extend each product to the accumulator width and sum.
    always_comb begin
        tree = '0;
        for (int i = 0; i < 9; i++) tree = tree + acc_t'(p[i]);
    end

    // Stage 2: register the accumulated sum.
    always_ff @(posedge clk) begin
        if (!rst)    sum <= '0;
        else if (en) sum <= tree;
    end

    mul_add_sat u_sat (
        .sum (sum),
        .pix (sat_pix)
    );

    // Stage 3: register the rescaled, saturated pixel.
    always_ff @(posedge clk) begin
        if (!rst)    out_pix <= '0;
        else if (en) out_pix <= sat_pix;
    end

endmodule

// File: tb/tb_mul_add.sv
// tb_mul_add: directed self-checking bench for mul_add (expectations follow MUL_ADD_RELU_EN)
module tb_mul_add;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic signed [16:0] w [9];
    logic signed [16:0] s [9];
    logic signed [16:0] out_pix;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_add dut (
        .clk(clk), .rst(rst), .en(en),
        .kernel_weights0(w[0]), .kernel_weights1(w[1]), .kernel_weights2(w[2]),
        .kernel_weights3(w[3]), .kernel_weights4(w[4]), .kernel_weights5(w[5]),
        .kernel_weights6(w[6]), .kernel_weights7(w[7]), .kernel_weights8(w[8]),
        .subimage0(s[0]), .subimage1(s[1]), .subimage2(s[2]),
        .subimage3(s[3]), .subimage4(s[4]), .subimage5(s[5]),
        .subimage6(s[6]), .subimage7(s[7]), .subimage8(s[8]),
        .out_pix(out_pix)
    );

    task automatic check(input string tag, input logic signed [16:0] got, input logic signed [16:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic signed [16:0] relu(input logic signed [16:0] x);
`ifdef MUL_ADD_RELU_EN
        return (x < 0) ? 17'sd0 : x;
`else
        return x;
`endif
    endfunction

    task automatic set_all(input logic signed [16:0] wv, input logic signed [16:0] sv);
        for (int i = 0; i < 9; i++) begin
            w[i] = wv;
            s[i] = sv;
        end
    endtask

    task automatic set_one(input logic signed [16:0] wv, input logic signed [16:0] sv);
        set_all(17'sd0, 17'sd0);
        w[0] = wv;
        s[0] = sv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run3(input string tag, input logic signed [16:0] exp);
        repeat (3) step();
        check(tag, out_pix, exp);
    endtask

    logic signed [16:0] sw [6];
    logic signed [16:0] sp [6];
    logic signed [16:0] se [6];

    initial begin
        sw = '{17'sd256, 17'sd256, 17'sd512, -17'sd256, 17'sd1, -17'sd1};
        sp = '{17'sd1,   17'sd100, 17'sd3,   17'sd7,    17'sd255, 17'sd255};
        se = '{17'sd1,   17'sd100, 17'sd6,   -17'sd7,   17'sd0,  -17'sd1};

        // Reset held with live inputs and en=1.
        en = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 9; k++) begin
                w[k] = 17'($urandom);
                s[k] = 17'($urandom);
            end
            step();
            check("reset_hold", out_pix, 17'sd0);
        end

        // Release reset: identity result appears on the third enabled edge.
        set_all(17'sd256, 17'sd256);
        rst = 1'b1;
        step();
        check("post_reset_e1", out_pix, 17'sd0);
        step();
        check("post_reset_e2", out_pix, 17'sd0);
        step();
        check("identity", out_pix, 17'sd2304);

        set_one(-17'sd256, 17'sd512);
        run3("neg_512", relu(-17'sd512));
        set_one(-17'sd1, 17'sd1);
        run3("floor_neg1", relu(-17'sd1));
        set_one(17'sd255, 17'sd1);
        run3("floor_pos0", 17'sd0);

        set_all(17'sd65535, 17'sd65535);
        run3("sat_max", 17'sd65535);
        set_all(17'sd65535, -17'sd65536);
        run3("sat_min", relu(-17'sd65536));
        set_all(-17'sd65536, -17'sd65536);
        run3("sat_max_negneg", 17'sd65535);

        // Reset wins over en=0.
        set_all(17'sd256, 17'sd256);
        run3("pre_rst_en0", 17'sd2304);
        en = 1'b0;
        rst = 1'b0;
        step();
        check("rst_over_en", out_pix, 17'sd0);
        rst = 1'b1;
        en = 1'b1;

        // Stall: fill with Z (11), sample A (77), freeze 4 cycles on junk, resume with Y (5).
        set_one(17'sd256, 17'sd11);
        run3("stall_fill", 17'sd11);
        set_one(17'sd256, 17'sd77);
        step();
        check("stall_a_edge", out_pix, 17'sd11);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_one(17'sd256, 17'sd999 + 17'(i));
            step();
            check("stall_frozen", out_pix, 17'sd11);
        end
        en = 1'b1;
        set_one(17'sd256, 17'sd5);
        step();
        check("resume_e1", out_pix, 17'sd11);
        step();
        check("resume_a", out_pix, 17'sd77);
        step();
        check("resume_y", out_pix, 17'sd5);

        // Back-to-back stream of 6 vectors.
        for (int i = 0; i < 8; i++) begin
            if (i < 6) set_one(sw[i], sp[i]);
            step();
            if (i >= 2) check("stream", out_pix, relu(se[i-2]));
        end

        // Mid-stream reset: A, B, C in flight, reset on D, then E (2304).
        set_one(17'sd256, 17'sd21);
        step();
        set_one(17'sd256, 17'sd22);
        step();
        set_one(17'sd256, 17'sd23);
        step();
        check("mid_pre_a", out_pix, 17'sd21);
        set_one(17'sd256, 17'sd24);
        rst = 1'b0;
        step();
        check("mid_rst", out_pix, 17'sd0);
        rst = 1'b1;
        set_all(17'sd256, 17'sd256);
        step();
        check("mid_flush1", out_pix, 17'sd0);
        step();
        check("mid_flush2", out_pix, 17'sd0);
        step();
        check("mid_new", out_pix, 17'sd2304);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
